cm0_wic: RTL and testbench
==========================

CM0_WIC -- requirements
Module: cm0_wic

Interface
REQ-001 Parameter WICLINES, default 34: number of implemented wake-up lines; legal range 2..34.
REQ-002 sclk  input  1  free-running system clock; all state on rising edge.
REQ-003 sreset  input  1  reset, synchronous, active-high.
REQ-004 wic_en_req_i  input  1  PMU request to enter WIC mode.
REQ-005 wic_en_ack_o  output  1  WIC mode active acknowledge to PMU.
REQ-006 wic_ds_req_n_o  output  1  WIC mode request to core, active-low.
REQ-007 wic_ds_ack_n_i  input  1  core acknowledge, active-low.
REQ-008 wic_load_i  input  1  core pulse: capture mask.
REQ-009 wic_clear_i  input  1  core pulse: clear mask and pending.
REQ-010 wic_mask_isr_i  input  32  core IRQ sensitivity.
REQ-011 wic_mask_nmi_i  input  1  core NMI sensitivity.
REQ-012 wic_mask_rxev_i  input  1  core RXEV sensitivity.
REQ-013 nmi_i  input  1  NMI line, level.
REQ-014 rxev_i  input  1  event line, pulse or level.
REQ-015 irq_i  input  32  interrupt lines, level.
REQ-016 wic_mask_o  output  WICLINES  registered mask.
REQ-017 wic_pend_o  output  WICLINES  registered pending lines.
REQ-018 wakeup_o  output  1  PMU wake-up request.

Function
REQ-019 Line map: bit 0 NMI, bit 1 RXEV, bit n+2 IRQ[n]; bits at or above WICLINES shall not exist; inputs mapping beyond them are ignored.
REQ-020 Handshake FSM states: DISABLED, REQ, ENABLED, REL.
REQ-021 DISABLED: wic_ds_req_n_o=1, wic_en_ack_o=0; wic_en_req_i=1 -> REQ.
REQ-022 REQ: wic_ds_req_n_o=0; wic_ds_ack_n_i=0 -> ENABLED; else wic_en_req_i=0 -> REL; ack takes precedence when both occur.
REQ-023 ENABLED: wic_ds_req_n_o=0, wic_en_ack_o=1; wic_en_req_i=0 -> REL.
REQ-024 REL: wic_ds_req_n_o=1, wic_en_ack_o=0; wic_ds_ack_n_i=1 -> DISABLED.
REQ-025 wic_en_ack_o and wic_ds_req_n_o shall be registered (Moore outputs, one-cycle latency from triggering input).
REQ-026 wic_load_i in ENABLED: next mask = {irq mask, rxev mask, nmi mask}; pending cleared same edge.
REQ-027 wic_clear_i: mask and pending cleared next edge in any state; clear wins over simultaneous load.
REQ-028 wic_load_i outside ENABLED shall be ignored.
REQ-029 On leaving ENABLED (entry to REL) mask and pending shall be cleared.
REQ-030 Pending: per line, pend |= mask & line each edge when no load/clear occurs; sticky until clear, load or leaving ENABLED.
REQ-031 wakeup_o = OR of pending register; line asserted at edge N -> wakeup_o high from cycle N+1.
REQ-032 Line asserted in the same cycle as wic_load_i shall not set pending that edge; it sets pending next edge if still high.
REQ-033 rxev_i single-cycle pulse shall be captured if masked.

Reset
REQ-034 sreset: state DISABLED, wic_ds_req_n_o=1, wic_en_ack_o=0, wic_mask_o=0, wic_pend_o=0, wakeup_o=0.
REQ-035 sreset mid-handshake shall abandon the handshake and return to DISABLED next edge; sreset has priority over all inputs.

Structure
REQ-036 Package cm0_wic_pkg: FSM state encodings (2-bit), line index constants (NMI=0, RXEV=1, IRQ_BASE=2), maximum line count 34.
REQ-037 Sub-module cm0_wic_hsk: handshake FSM (REQ-020..025), exporting state-is-ENABLED and leaving-ENABLED strobes; mask/pending datapath stays in cm0_wic.
REQ-038 No clock gating, no combinational path input-to-output.

Verification
REQ-039 Enable: wic_en_req_i=1, core drives ack_n=0 two cycles later -> ds_req_n_o low at cycle 1, en_ack_o high one cycle after ack sampled.
REQ-040 Load mask_isr=0x00000010, mask_nmi=0, then irq_i[4]=1 for one cycle -> wic_pend_o bit 6 set, wakeup_o=1 next cycle, sticky after irq drops.
REQ-041 Unmasked lines: irq_i=0xFFFFFFEF, nmi_i=1 with mask from REQ-040 -> wic_pend_o unchanged, wakeup_o=0.
REQ-042 Simultaneous wic_load_i and wic_clear_i with pending=0x40 -> mask=0, pending=0, wakeup_o=0.
REQ-043 Abort: en_req drops while in REQ with ack_n=1 -> REL, ds_req_n_o=1, DISABLED when ack_n=1; loads in REQ ignored.
REQ-044 WICLINES=4: irq_i[5]=1 with full mask -> no pending; sreset in ENABLED with pending -> all outputs reset values next cycle.

Source files
------------

// File: rtl/cm0_wic_pkg.sv
// rtl/cm0_wic_pkg.sv - shared types and constants for the wake-up interrupt controller
//
// Purpose: handshake FSM state encoding, wake-up line index map and a helper
// that packs the NMI/RXEV/IRQ inputs into the line vector layout.
// Ports: none (package).
package cm0_wic_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_REQ      = 2'd1,
    ST_ENABLED  = 2'd2,
    ST_REL      = 2'd3
  } wic_state_e;

  localparam int LINE_NMI      = 0;
  localparam int LINE_RXEV     = 1;
  localparam int LINE_IRQ_BASE = 2;
  localparam int IRQ_LINES     = 32;
  localparam int MAX_LINES     = 34;

  // Bit 0 NMI, bit 1 RXEV, bit n+2 IRQ[n].
  function automatic logic [MAX_LINES-1:0] pack_lines(
    input logic                 nmi,
    input logic                 rxev,
    input logic [IRQ_LINES-1:0] irq
  );
    logic [MAX_LINES-1:0] v;
    v                                  = '0;
    v[LINE_NMI]                        = nmi;
    v[LINE_RXEV]                       = rxev;
    v[LINE_IRQ_BASE +: IRQ_LINES]      = irq;
    return v;
  endfunction

endpackage

// File: rtl/cm0_wic_if.sv
// rtl/cm0_wic_if.sv - PMU/core deep-sleep handshake bundle
//
// Purpose: groups the WIC enable request/acknowledge signals exchanged with
// the PMU and the core.
// Signals: wic_en_req_i (PMU request), wic_en_ack_o (WIC active ack),
//          wic_ds_req_n_o (request to core, active-low),
//          wic_ds_ack_n_i (core ack, active-low).
// Modports: master = PMU/core side, slave = WIC side.
interface cm0_wic_if;

  logic wic_en_req_i;
  logic wic_en_ack_o;
  logic wic_ds_req_n_o;
  logic wic_ds_ack_n_i;

  modport master (
    output wic_en_req_i,
    output wic_ds_ack_n_i,
    input  wic_en_ack_o,
    input  wic_ds_req_n_o
  );

  modport slave (
    input  wic_en_req_i,
    input  wic_ds_ack_n_i,
    output wic_en_ack_o,
    output wic_ds_req_n_o
  );

endinterface

// File: rtl/cm0_wic_hsk.sv
// rtl/cm0_wic_hsk.sv - WIC enable handshake FSM
//
// Purpose: sequences DISABLED -> REQ -> ENABLED -> REL -> DISABLED between
// the PMU request and the core acknowledge, with registered outputs.
// Ports: clk, rst (sync, active-high); en_req, ds_ack_n in;
//        en_ack, ds_req_n registered out; is_enabled (state is ENABLED);
//        leave_enabled (this edge moves ENABLED -> REL).
module cm0_wic_hsk
  import cm0_wic_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_req,
  input  logic ds_ack_n,
  output logic en_ack,
  output logic ds_req_n,
  output logic is_enabled,
  output logic leave_enabled
);

  wic_state_e state;

  assign is_enabled    = (state == ST_ENABLED);
  // Lets the datapath clear mask/pending on the same edge that enters REL.
  assign leave_enabled = (state == ST_ENABLED) && !en_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_DISABLED;
      ds_req_n <= 1'b1;
      en_ack   <= 1'b0;
    end else begin
      case (state)
        ST_DISABLED: begin
          if (en_req) begin
            state    <= ST_REQ;
            ds_req_n <= 1'b0;
          end
        end
        ST_REQ: begin
          // Core ack wins over a simultaneous PMU withdrawal.
          if (!ds_ack_n) begin
            state  <= ST_ENABLED;
            en_ack <= 1'b1;
          end else if (!en_req) begin
            state    <= ST_REL;
            ds_req_n <= 1'b1;
          end
        end
        ST_ENABLED: begin
          if (!en_req) begin
            state    <= ST_REL;
            ds_req_n <= 1'b1;
            en_ack   <= 1'b0;
          end
        end
        ST_REL: begin
          if (ds_ack_n) begin
            state <= ST_DISABLED;
          end
        end
        default: begin
          state    <= ST_DISABLED;
          ds_req_n <= 1'b1;
          en_ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cm0_wic.sv
// rtl/cm0_wic.sv - wake-up interrupt controller top
//
// Purpose: captures the core's interrupt sensitivity mask while WIC mode is
// active, latches masked lines as sticky pending bits and raises wakeup_o.
// Ports: sclk, sreset (sync, active-high); hsk (cm0_wic_if.slave handshake);
//        wic_load_i / wic_clear_i core pulses; wic_mask_isr_i/nmi_i/rxev_i
//        sensitivity; nmi_i, rxev_i, irq_i lines; wic_mask_o, wic_pend_o
//        registered WICLINES-wide; wakeup_o = OR of pending.
module cm0_wic
  import cm0_wic_pkg::*;
#(
  parameter int WICLINES = 34
) (
  input  logic                 sclk,
  input  logic                 sreset,
  cm0_wic_if.slave             hsk,
  input  logic                 wic_load_i,
  input  logic                 wic_clear_i,
  input  logic [IRQ_LINES-1:0] wic_mask_isr_i,
  input  logic                 wic_mask_nmi_i,
  input  logic                 wic_mask_rxev_i,
  input  logic                 nmi_i,
  input  logic                 rxev_i,
  input  logic [IRQ_LINES-1:0] irq_i,
  output logic [WICLINES-1:0]  wic_mask_o,
  output logic [WICLINES-1:0]  wic_pend_o,
  output logic                 wakeup_o
);

  logic                 is_enabled;
  logic                 leave_enabled;
  logic [MAX_LINES-1:0] all_lines;
  logic [MAX_LINES-1:0] all_mask;
  logic [WICLINES-1:0]  lines;
  logic [WICLINES-1:0]  load_mask;

  cm0_wic_hsk u_hsk (
    .clk           (sclk),
    .rst           (sreset),
    .en_req        (hsk.wic_en_req_i),
    .ds_ack_n      (hsk.wic_ds_ack_n_i),
    .en_ack        (hsk.wic_en_ack_o),
    .ds_req_n      (hsk.wic_ds_req_n_o),
    .is_enabled    (is_enabled),
    .leave_enabled (leave_enabled)
  );

  // Lines above WICLINES are simply dropped here.
  assign all_lines = pack_lines(nmi_i, rxev_i, irq_i);
  assign all_mask  = pack_lines(wic_mask_nmi_i, wic_mask_rxev_i, wic_mask_isr_i);
  assign lines     = all_lines[WICLINES-1:0];
  assign load_mask = all_mask[WICLINES-1:0];

  // Priority: reset, clear, leaving ENABLED, load, then accumulation.
  // A load edge clears pending, so a line high in the load cycle only
  // lands in pending on the following edge.
  always_ff @(posedge sclk) begin
    if (sreset) begin
      wic_mask_o <= '0;
      wic_pend_o <= '0;
    end else if (wic_clear_i || leave_enabled) begin
      wic_mask_o <= '0;
      wic_pend_o <= '0;
    end else if (wic_load_i && is_enabled) begin
      wic_mask_o <= load_mask;
      wic_pend_o <= '0;
    end else begin
      wic_pend_o <= wic_pend_o | (wic_mask_o & lines);
    end
  end

  assign wakeup_o = |wic_pend_o;

endmodule

// File: tb/tb_cm0_wic.sv
// tb/tb_cm0_wic.sv - directed self-checking bench for cm0_wic
module tb_cm0_wic;

  logic        sclk;
  logic        sreset;
  logic        en_req;
  logic        ds_ack_n;
  logic        load;
  logic        clear;
  logic [31:0] mask_isr;
  logic        mask_nmi;
  logic        mask_rxev;
  logic        nmi;
  logic        rxev;
  logic [31:0] irq;

  logic [33:0] mask34;
  logic [33:0] pend34;
  logic        wake34;
  logic [3:0]  mask4;
  logic [3:0]  pend4;
  logic        wake4;

  int n_cmp;
  int n_bad;

  cm0_wic_if if34 ();
  cm0_wic_if if4 ();

  assign if34.wic_en_req_i   = en_req;
  assign if34.wic_ds_ack_n_i = ds_ack_n;
  assign if4.wic_en_req_i    = en_req;
  assign if4.wic_ds_ack_n_i  = ds_ack_n;

  cm0_wic #(.WICLINES(34)) dut (
    .sclk            (sclk),
    .sreset          (sreset),
    .hsk             (if34.slave),
    .wic_load_i      (load),
    .wic_clear_i     (clear),
    .wic_mask_isr_i  (mask_isr),
    .wic_mask_nmi_i  (mask_nmi),
    .wic_mask_rxev_i (mask_rxev),
    .nmi_i           (nmi),
    .rxev_i          (rxev),
    .irq_i           (irq),
    .wic_mask_o      (mask34),
    .wic_pend_o      (pend34),
    .wakeup_o        (wake34)
  );

  cm0_wic #(.WICLINES(4)) dut4 (
    .sclk            (sclk),
    .sreset          (sreset),
    .hsk             (if4.slave),
    .wic_load_i      (load),
    .wic_clear_i     (clear),
    .wic_mask_isr_i  (mask_isr),
    .wic_mask_nmi_i  (mask_nmi),
    .wic_mask_rxev_i (mask_rxev),
    .nmi_i           (nmi),
    .rxev_i          (rxev),
    .irq_i           (irq),
    .wic_mask_o      (mask4),
    .wic_pend_o      (pend4),
    .wakeup_o        (wake4)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic test_reset();
    sreset = 1'b1;
    tick();
    tick();
    n_cmp++; if (if34.wic_ds_req_n_o !== 1'b1) begin n_bad++; $display("FAIL rst_ds_req_n: got %b want 1", if34.wic_ds_req_n_o); end
    n_cmp++; if (if34.wic_en_ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_en_ack: got %b want 0", if34.wic_en_ack_o); end
    n_cmp++; if (mask34 !== 34'h0) begin n_bad++; $display("FAIL rst_mask: got %h want 0", mask34); end
    n_cmp++; if (pend34 !== 34'h0) begin n_bad++; $display("FAIL rst_pend: got %h want 0", pend34); end
    n_cmp++; if (wake34 !== 1'b0) begin n_bad++; $display("FAIL rst_wakeup: got %b want 0", wake34); end
    sreset = 1'b0;
  endtask

  task automatic test_enable();
    en_req   = 1'b1;
    ds_ack_n = 1'b1;
    tick();
    n_cmp++; if (if34.wic_ds_req_n_o !== 1'b0) begin n_bad++; $display("FAIL en_ds_req_n_c1: got %b want 0", if34.wic_ds_req_n_o); end
    n_cmp++; if (if34.wic_en_ack_o !== 1'b0) begin n_bad++; $display("FAIL en_ack_c1: got %b want 0", if34.wic_en_ack_o); end
    tick();
    n_cmp++; if (if34.wic_en_ack_o !== 1'b0) begin n_bad++; $display("FAIL en_ack_c2: got %b want 0", if34.wic_en_ack_o); end
    ds_ack_n = 1'b0;
    tick();
    n_cmp++; if (if34.wic_en_ack_o !== 1'b1) begin n_bad++; $display("FAIL en_ack_after_ack: got %b want 1", if34.wic_en_ack_o); end
    n_cmp++; if (if34.wic_ds_req_n_o !== 1'b0) begin n_bad++; $display("FAIL en_ds_req_n_enabled: got %b want 0", if34.wic_ds_req_n_o); end
  endtask

  task automatic test_load_irq();
    mask_isr  = 32'h0000_0010;
    mask_nmi  = 1'b0;
    mask_rxev = 1'b0;
    load      = 1'b1;
    tick();
    load = 1'b0;
    n_cmp++; if (mask34 !== 34'h40) begin n_bad++; $display("FAIL load_mask: got %h want 40", mask34); end
    n_cmp++; if (pend34 !== 34'h0) begin n_bad++; $display("FAIL load_pend: got %h want 0", pend34); end
    irq = 32'h0000_0010;
    tick();
    irq = 32'h0;
    n_cmp++; if (pend34 !== 34'h40) begin n_bad++; $display("FAIL irq4_pend: got %h want 40", pend34); end
    n_cmp++; if (wake34 !== 1'b1) begin n_bad++; $display("FAIL irq4_wakeup: got %b want 1", wake34); end
    tick();
    n_cmp++; if (pend34 !== 34'h40) begin n_bad++; $display("FAIL irq4_sticky: got %h want 40", pend34); end
  endtask

  task automatic test_unmasked();
    load = 1'b1;
    tick();
    load = 1'b0;
    n_cmp++; if (pend34 !== 34'h0) begin n_bad++; $display("FAIL reload_pend: got %h want 0", pend34); end
    irq = 32'hFFFF_FFEF;
    nmi = 1'b1;
    tick();
    tick();
    n_cmp++; if (pend34 !== 34'h0) begin n_bad++; $display("FAIL unmasked_pend: got %h want 0", pend34); end
    n_cmp++; if (wake34 !== 1'b0) begin n_bad++; $display("FAIL unmasked_wakeup: got %b want 0", wake34); end
    irq = 32'h0;
    nmi = 1'b0;
  endtask

  task automatic test_load_same_cycle();
    load = 1'b1;
    irq  = 32'h0000_0010;
    tick();
    load = 1'b0;
    n_cmp++; if (pend34 !== 34'h0) begin n_bad++; $display("FAIL load_cycle_pend: got %h want 0", pend34); end
    tick();
    irq = 32'h0;
    n_cmp++; if (pend34 !== 34'h40) begin n_bad++; $display("FAIL load_next_pend: got %h want 40", pend34); end
  endtask

  task automatic test_load_clear();
    load  = 1'b1;
    clear = 1'b1;
    tick();
    load  = 1'b0;
    clear = 1'b0;
    n_cmp++; if (mask34 !== 34'h0) begin n_bad++; $display("FAIL ldclr_mask: got %h want 0", mask34); end
    n_cmp++; if (pend34 !== 34'h0) begin n_bad++; $display("FAIL ldclr_pend: got %h want 0", pend34); end
    n_cmp++; if (wake34 !== 1'b0) begin n_bad++; $display("FAIL ldclr_wakeup: got %b want 0", wake34); end
  endtask

  task automatic test_rxev_pulse();
    mask_isr  = 32'h0;
    mask_rxev = 1'b1;
    load      = 1'b1;
    tick();
    load = 1'b0;
    rxev = 1'b1;
    tick();
    rxev = 1'b0;
    tick();
    n_cmp++; if (pend34 !== 34'h2) begin n_bad++; $display("FAIL rxev_pend: got %h want 2", pend34); end
    n_cmp++; if (wake34 !== 1'b1) begin n_bad++; $display("FAIL rxev_wakeup: got %b want 1", wake34); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if (pend34 !== 34'h0) begin n_bad++; $display("FAIL clear_pend: got %h want 0", pend34); end
    mask_rxev = 1'b0;
  endtask

  task automatic test_leave();
    mask_isr = 32'h0000_0010;
    load     = 1'b1;
    tick();
    load = 1'b0;
    irq  = 32'h0000_0010;
    tick();
    irq    = 32'h0;
    en_req = 1'b0;
    tick();
    n_cmp++; if (if34.wic_ds_req_n_o !== 1'b1) begin n_bad++; $display("FAIL leave_ds_req_n: got %b want 1", if34.wic_ds_req_n_o); end
    n_cmp++; if (if34.wic_en_ack_o !== 1'b0) begin n_bad++; $display("FAIL leave_en_ack: got %b want 0", if34.wic_en_ack_o); end
    n_cmp++; if (mask34 !== 34'h0) begin n_bad++; $display("FAIL leave_mask: got %h want 0", mask34); end
    n_cmp++; if (pend34 !== 34'h0) begin n_bad++; $display("FAIL leave_pend: got %h want 0", pend34); end
    tick();
    n_cmp++; if (if34.wic_ds_req_n_o !== 1'b1) begin n_bad++; $display("FAIL rel_hold_ds_req_n: got %b want 1", if34.wic_ds_req_n_o); end
    ds_ack_n = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    en_req = 1'b1;
    tick();
    n_cmp++; if (if34.wic_ds_req_n_o !== 1'b0) begin n_bad++; $display("FAIL abort_req_ds_req_n: got %b want 0", if34.wic_ds_req_n_o); end
    load   = 1'b1;
    en_req = 1'b0;
    tick();
    load = 1'b0;
    n_cmp++; if (mask34 !== 34'h0) begin n_bad++; $display("FAIL abort_load_mask: got %h want 0", mask34); end
    n_cmp++; if (if34.wic_ds_req_n_o !== 1'b1) begin n_bad++; $display("FAIL abort_rel_ds_req_n: got %b want 1", if34.wic_ds_req_n_o); end
    n_cmp++; if (if34.wic_en_ack_o !== 1'b0) begin n_bad++; $display("FAIL abort_en_ack: got %b want 0", if34.wic_en_ack_o); end
    tick();
    // Now DISABLED: a fresh request must reach REQ on the next edge.
    en_req = 1'b1;
    tick();
    n_cmp++; if (if34.wic_ds_req_n_o !== 1'b0) begin n_bad++; $display("FAIL abort_rereq_ds_req_n: got %b want 0", if34.wic_ds_req_n_o); end
    en_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    en_req = 1'b1;
    tick();
    en_req   = 1'b0;
    ds_ack_n = 1'b0;
    tick();
    n_cmp++; if (if34.wic_en_ack_o !== 1'b1) begin n_bad++; $display("FAIL prec_en_ack: got %b want 1", if34.wic_en_ack_o); end
    n_cmp++; if (if34.wic_ds_req_n_o !== 1'b0) begin n_bad++; $display("FAIL prec_ds_req_n: got %b want 0", if34.wic_ds_req_n_o); end
    tick();
    n_cmp++; if (if34.wic_en_ack_o !== 1'b0) begin n_bad++; $display("FAIL prec_rel_en_ack: got %b want 0", if34.wic_en_ack_o); end
    ds_ack_n = 1'b1;
    tick();
  endtask

  task automatic test_wiclines4();
    en_req = 1'b1;
    tick();
    ds_ack_n = 1'b0;
    tick();
    mask_isr  = 32'hFFFF_FFFF;
    mask_nmi  = 1'b1;
    mask_rxev = 1'b1;
    load      = 1'b1;
    tick();
    load = 1'b0;
    n_cmp++; if (mask4 !== 4'hF) begin n_bad++; $display("FAIL w4_mask: got %h want f", mask4); end
    n_cmp++; if (mask34 !== 34'h3_FFFF_FFFF) begin n_bad++; $display("FAIL w34_full_mask: got %h want 3ffffffff", mask34); end
    irq = 32'h0000_0020;
    tick();
    irq = 32'h0;
    n_cmp++; if (pend4 !== 4'h0) begin n_bad++; $display("FAIL w4_irq5_pend: got %h want 0", pend4); end
    n_cmp++; if (wake4 !== 1'b0) begin n_bad++; $display("FAIL w4_irq5_wakeup: got %b want 0", wake4); end
    n_cmp++; if (pend34 !== 34'h80) begin n_bad++; $display("FAIL w34_irq5_pend: got %h want 80", pend34); end
    irq = 32'h0000_0002;
    tick();
    irq = 32'h0;
    n_cmp++; if (pend4 !== 4'h8) begin n_bad++; $display("FAIL w4_irq1_pend: got %h want 8", pend4); end
    n_cmp++; if (wake4 !== 1'b1) begin n_bad++; $display("FAIL w4_irq1_wakeup: got %b want 1", wake4); end
    sreset = 1'b1;
    tick();
    n_cmp++; if (if4.wic_ds_req_n_o !== 1'b1) begin n_bad++; $display("FAIL srst_ds_req_n: got %b want 1", if4.wic_ds_req_n_o); end
    n_cmp++; if (if4.wic_en_ack_o !== 1'b0) begin n_bad++; $display("FAIL srst_en_ack: got %b want 0", if4.wic_en_ack_o); end
    n_cmp++; if (mask4 !== 4'h0) begin n_bad++; $display("FAIL srst_mask4: got %h want 0", mask4); end
    n_cmp++; if (pend4 !== 4'h0) begin n_bad++; $display("FAIL srst_pend4: got %h want 0", pend4); end
    n_cmp++; if (wake4 !== 1'b0) begin n_bad++; $display("FAIL srst_wakeup4: got %b want 0", wake4); end
    n_cmp++; if (pend34 !== 34'h0) begin n_bad++; $display("FAIL srst_pend34: got %h want 0", pend34); end
    n_cmp++; if (if34.wic_en_ack_o !== 1'b0) begin n_bad++; $display("FAIL srst_en_ack34: got %b want 0", if34.wic_en_ack_o); end
    en_req   = 1'b0;
    ds_ack_n = 1'b1;
    sreset   = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    sreset    = 1'b1;
    en_req    = 1'b0;
    ds_ack_n  = 1'b1;
    load      = 1'b0;
    clear     = 1'b0;
    mask_isr  = 32'h0;
    mask_nmi  = 1'b0;
    mask_rxev = 1'b0;
    nmi       = 1'b0;
    rxev      = 1'b0;
    irq       = 32'h0;
    test_reset();
    test_enable();
    test_load_irq();
    test_unmasked();
    test_load_same_cycle();
    test_load_clear();
    test_rxev_pulse();
    test_leave();
    test_abort();
    test_back_to_back();
    test_wiclines4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
